// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and dmem_responder.
// The master drives the request side; the slave returns data, strobe and status.
interface dmem_responder_if;
  logic        req;
  logic [3:0]  wemen;
  logic [3:0]  re;
  logic [31:0] daddr;
  logic [31:0] wdata;
  logic        signcontrol;
  logic [31:0] rdata;
  logic        valid;
  logic        busy;
  logic        err;

  modport master (
    output req, wemen, re, daddr, wdata, signcontrol,
    input  rdata, valid, busy, err
  );

  modport slave (
    input  req, wemen, re, daddr, wdata, signcontrol,
    output rdata, valid, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-lane stores/loads and WAIT_CYCLES+1 wait cycles per access.
// Define DMEM_REQ_CHECK_EN to reject malformed or out-of-range requests with err=1.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic [31:0]           rdata_reg;
  logic [3:0]            wemen_reg;
  logic [3:0]            re_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [31:0]           wdata_reg;
  logic                  sign_reg;

  logic [DEPTH_LOG2-1:0] idx_in;
  logic [31:0]           rd_word;
  logic [31:0]           wr_word;
  logic [31:0]           load_val;
  logic [31:0]           resp_data;
  logic [3:0]            lane_we;
  logic                  reject;
  logic                  commit;

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15: mask_legal = 1'b1;
      default:                                           mask_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    ext8 = {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    ext16 = {{16{s & h[15]}}, h};
  endfunction

  assign idx_in = bus.daddr[DEPTH_LOG2-1:0];

  // One byte-wide RAM per lane. The read is launched while IDLE so the word is
  // already registered before the earliest possible commit edge (WAIT_CYCLES=0).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (commit && lane_we[gi]) begin
          mem[idx_reg] <= wr_word[8*gi +: 8];
        end
        if (state_reg == IDLE) begin
          rd_q <= mem[idx_in];
        end
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Right-justified store data is replicated so every legal mask finds its bytes in place.
  always_comb begin
    wr_word = wdata_reg;
    case (wemen_reg)
      4'd1, 4'd2, 4'd4, 4'd8: wr_word = {4{wdata_reg[7:0]}};
      4'd3, 4'd12:            wr_word = {2{wdata_reg[15:0]}};
      default:                wr_word = wdata_reg;
    endcase
  end

  always_comb begin
    load_val = '0;
    case (re_reg)
      4'd1:    load_val = ext8(rd_word[7:0], sign_reg);
      4'd2:    load_val = ext8(rd_word[15:8], sign_reg);
      4'd4:    load_val = ext8(rd_word[23:16], sign_reg);
      4'd8:    load_val = ext8(rd_word[31:24], sign_reg);
      4'd3:    load_val = ext16(rd_word[15:0], sign_reg);
      4'd12:   load_val = ext16(rd_word[31:16], sign_reg);
      4'd15:   load_val = rd_word;
      default: load_val = '0;
    endcase
  end

`ifdef DMEM_REQ_CHECK_EN
  logic oor_reg;
  logic err_reg;

  assign reject = !mask_legal(wemen_reg) || !mask_legal(re_reg) ||
                  ((wemen_reg != 4'd0) && (re_reg != 4'd0)) || oor_reg;
  assign bus.err = err_reg;
`else
  logic unused_daddr_hi;

  assign unused_daddr_hi = |bus.daddr[31:DEPTH_LOG2];
  assign reject          = 1'b0;
  assign bus.err         = 1'b0;
`endif

  // A request that stores never returns load data, even when re is also set.
  assign lane_we   = (reject || !mask_legal(wemen_reg)) ? 4'd0 : wemen_reg;
  assign resp_data = (reject || (wemen_reg != 4'd0)) ? 32'd0 : load_val;
  assign commit    = (state_reg == WAIT) && (cnt_reg == 4'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      rdata_reg <= 32'd0;
`ifdef DMEM_REQ_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            wemen_reg <= bus.wemen;
            re_reg    <= bus.re;
            idx_reg   <= idx_in;
            wdata_reg <= bus.wdata;
            sign_reg  <= bus.signcontrol;
`ifdef DMEM_REQ_CHECK_EN
            oor_reg   <= (bus.daddr >> DEPTH_LOG2) != 32'd0;
`endif
            cnt_reg   <= WAIT_INIT;
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            valid_reg <= 1'b1;
            rdata_reg <= resp_data;
`ifdef DMEM_REQ_CHECK_EN
            err_reg   <= reject;
`endif
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
`ifdef DMEM_REQ_CHECK_EN
          err_reg   <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_reg;
  assign bus.valid = valid_reg;
  assign bus.busy  = busy_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences,
// then random traffic checked against a byte-lane memory model.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int DEPTH_LOG2  = 8;
  localparam int WAIT_CYCLES = 1;
  localparam int LAT         = WAIT_CYCLES + 2;
`ifdef DMEM_REQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  we;
    logic [3:0]  re;
    logic [31:0] a;
    logic [31:0] wd;
    logic        sc;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] ref_mem [int];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(input string name, input logic [3:0] we, input logic [3:0] re,
                              input logic [31:0] a, input logic [31:0] wd, input logic sc,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.a = a; v.wd = wd; v.sc = sc;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: lanes named by a mask map, in order, onto consecutive data bytes.
  function automatic logic legal(input logic [3:0] m);
    return m inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [3:0] m,
                                              input logic [31:0] wd);
    logic [31:0] w = old;
    int n = 0;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        w[8*l +: 8] = wd[8*n +: 8];
        n++;
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [3:0] m,
                                             input logic sc);
    logic [31:0] r = 32'd0;
    int n = 0;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        r[8*n +: 8] = word[8*l +: 8];
        n++;
      end
    end
    if (sc && n > 0 && n < 4 && r[8*n-1]) begin
      for (int k = n; k < 4; k++) r[8*k +: 8] = 8'hFF;
    end
    return r;
  endfunction

  task automatic model_xact(input logic [3:0] we, input logic [3:0] re, input logic [31:0] a,
                            input logic [31:0] wd, input logic sc,
                            output logic [31:0] exp_rd, output logic exp_err);
    int idx = int'(a[DEPTH_LOG2-1:0]);
    bit oor = (a >> DEPTH_LOG2) != 32'd0;
    bit rej = CHK && (!legal(we) || !legal(re) || (we != 4'd0 && re != 4'd0) || oor);
    exp_err = rej;
    exp_rd  = 32'd0;
    if (!rej) begin
      if (legal(we) && we != 4'd0) ref_mem[idx] = model_store(ref_mem[idx], we, wd);
      if (we == 4'd0 && legal(re)) exp_rd = model_load(ref_mem[idx], re, sc);
    end
  endtask

  task automatic xact(input logic [3:0] we, input logic [3:0] re, input logic [31:0] a,
                      input logic [31:0] wd, input logic sc,
                      output logic [31:0] rd, output logic e, output int lat);
    bit found = 0;
    rd  = 'x;
    e   = 1'bx;
    lat = -1;
    @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.req = 1'b1; bus.wemen = we; bus.re = re; bus.daddr = a;
    bus.wdata = wd; bus.signcontrol = sc;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        found = 1; lat = i; rd = bus.rdata; e = bus.err;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [3:0] we, input logic [3:0] re,
                           input logic [31:0] a, input logic [31:0] wd, input logic sc,
                           input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    xact(we, re, a, wd, sc, rd, e, lat);
    $display("txn %s we=%h re=%h a=%h wd=%h sc=%b -> rdata=%h err=%b lat=%0d (exp %h/%b/%0d)",
             name, we, re, a, wd, sc, rd, e, lat, exp_rd, exp_err, LAT);
    check({name, "_lat"}, 32'(lat), 32'(LAT));
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic rand_txn(input string name, input logic [3:0] we, input logic [3:0] re,
                          input logic [31:0] a, input logic [31:0] wd, input logic sc);
    logic [31:0] exp_rd;
    logic        exp_err;
    model_xact(we, re, a, wd, sc, exp_rd, exp_err);
    run_check(name, we, re, a, wd, sc, exp_rd, exp_err);
  endtask

  function automatic logic [3:0] legal_nz();
    logic [3:0] lm [7] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
    return lm[$urandom_range(0, 6)];
  endfunction

  function automatic logic [3:0] illegal_mask();
    logic [3:0] m = 4'd5;
    for (int t = 0; t < 50; t++) begin
      m = 4'($urandom_range(0, 15));
      if (!legal(m)) break;
    end
    if (legal(m)) m = 4'd5;
    return m;
  endfunction

  initial begin
    int          p, n_cyc, nvalid, nidle, bad_gap, last;
    logic [31:0] last_rd;
    logic [3:0]  we, re;
    logic [31:0] a;
    int          kind;

    reset = 1'b1;
    bus.req = 1'b0; bus.wemen = 4'd0; bus.re = 4'd0; bus.daddr = 32'd0;
    bus.wdata = 32'd0; bus.signcontrol = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_err",   {31'd0, bus.err},   32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b0;

    tbl.push_back(mk("st_word",     4'hF, 4'h0, 32'd5, 32'h8899AABB, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_word",     4'h0, 4'hF, 32'd5, 32'h0, 1'b0, 32'h8899AABB, 1'b0));
    tbl.push_back(mk("st_init7",    4'hF, 4'h0, 32'd7, 32'h11223344, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("st_byte2",    4'h4, 4'h0, 32'd7, 32'h000000F0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_b2_sx",    4'h0, 4'h4, 32'd7, 32'h0, 1'b1, 32'hFFFFFFF0, 1'b0));
    tbl.push_back(mk("ld_b2_zx",    4'h0, 4'h4, 32'd7, 32'h0, 1'b0, 32'h000000F0, 1'b0));
    tbl.push_back(mk("ld_w7",       4'h0, 4'hF, 32'd7, 32'h0, 1'b0, 32'h11F03344, 1'b0));
    tbl.push_back(mk("st_hw_hi",    4'hC, 4'h0, 32'd7, 32'h00007FFE, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_hw_hi_sx", 4'h0, 4'hC, 32'd7, 32'h0, 1'b1, 32'h00007FFE, 1'b0));
    tbl.push_back(mk("ld_w7b",      4'h0, 4'hF, 32'd7, 32'h0, 1'b0, 32'h7FFE3344, 1'b0));
    tbl.push_back(mk("ld_re5",      4'h0, 4'h5, 32'd7, 32'h0, 1'b1, 32'h0, CHK));
    tbl.push_back(mk("st_ld_both",  4'hF, 4'hF, 32'd7, 32'hDEADBEEF, 1'b0, 32'h0, CHK));
    tbl.push_back(mk("ld_w7c",      4'h0, 4'hF, 32'd7, 32'h0, 1'b0,
                     CHK ? 32'h7FFE3344 : 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk("noop",        4'h0, 4'h0, 32'd7, 32'h0, 1'b1, 32'h0, 1'b0));
    tbl.push_back(mk("ld_wrap",     4'h0, 4'hF, 32'h105, 32'h0, 1'b0,
                     CHK ? 32'h0 : 32'h8899AABB, CHK));
    tbl.push_back(mk("ld_hw_lo_sx", 4'h0, 4'h3, 32'd5, 32'h0, 1'b1, 32'hFFFFAABB, 1'b0));
    tbl.push_back(mk("ld_b1_zx",    4'h0, 4'h2, 32'd5, 32'h0, 1'b0, 32'h000000AA, 1'b0));
    tbl.push_back(mk("ld_b3_sx",    4'h0, 4'h8, 32'd5, 32'h0, 1'b1, 32'hFFFFFF88, 1'b0));
    tbl.push_back(mk("st_b0",       4'h1, 4'h0, 32'd5, 32'h12345677, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_w5",       4'h0, 4'hF, 32'd5, 32'h0, 1'b0, 32'h8899AA77, 1'b0));
    tbl.push_back(mk("st_illegal",  4'h6, 4'h0, 32'd5, 32'hFFFFFFFF, 1'b0, 32'h0, CHK));
    tbl.push_back(mk("ld_w5b",      4'h0, 4'hF, 32'd5, 32'h0, 1'b0, 32'h8899AA77, 1'b0));
    tbl.push_back(mk("ld_hw_lo_zx", 4'h0, 4'h3, 32'd5, 32'h0, 1'b0, 32'h0000AA77, 1'b0));

    foreach (tbl[i]) begin
      run_check(tbl[i].name, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].sc,
                tbl[i].exp_rd, tbl[i].exp_err);
    end

    // req held high: one response every WAIT_CYCLES+3 cycles, busy low only in IDLE.
    p = WAIT_CYCLES + 3;
    n_cyc = 10 * p;
    nvalid = 0; nidle = 0; bad_gap = 0; last = -1; last_rd = 32'd0;
    @(negedge clk);
    bus.req = 1'b1; bus.wemen = 4'd0; bus.re = 4'hF; bus.daddr = 32'd5;
    bus.wdata = 32'd0; bus.signcontrol = 1'b0;
    for (int i = 1; i <= n_cyc; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        nvalid++;
        if (last < 0 && i != LAT) bad_gap++;
        if (last >= 0 && (i - last) != p) bad_gap++;
        last = i;
        last_rd = bus.rdata;
      end
      if (!bus.busy) nidle++;
    end
    bus.req = 1'b0;
    $display("txn held_req cycles=%0d valids=%0d idle=%0d bad_gaps=%0d", n_cyc, nvalid, nidle, bad_gap);
    check("held_valid_count", 32'(nvalid), 32'd10);
    check("held_idle_count",  32'(nidle),  32'd10);
    check("held_gaps",        32'(bad_gap), 32'd0);
    check("held_rdata",       last_rd, 32'h8899AA77);

    // Reset in the first WAIT cycle of a store aborts it.
    @(negedge clk);
    bus.req = 1'b1; bus.wemen = 4'hF; bus.re = 4'd0; bus.daddr = 32'd5; bus.wdata = 32'h0;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",  {31'd0, bus.busy},  32'd0);
    check("abort_valid", {31'd0, bus.valid}, 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    nvalid = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    $display("txn reset_abort valids_after=%0d", nvalid);
    check("abort_no_valid", 32'(nvalid), 32'd0);
    run_check("ld_after_abort", 4'h0, 4'hF, 32'd5, 32'h0, 1'b0, 32'h8899AA77, 1'b0);

    // Reset and req in the same cycle: request dropped.
    @(negedge clk);
    reset = 1'b1; bus.req = 1'b1; bus.wemen = 4'hF; bus.re = 4'd0;
    bus.daddr = 32'd5; bus.wdata = 32'h0;
    @(negedge clk);
    reset = 1'b0; bus.req = 1'b0;
    nvalid = 0; nidle = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
      if (!bus.busy) nidle++;
    end
    $display("txn reset_with_req valids=%0d idle=%0d", nvalid, nidle);
    check("rstreq_no_valid", 32'(nvalid), 32'd0);
    check("rstreq_idle",     32'(nidle),  32'd6);
    run_check("ld_after_rstreq", 4'h0, 4'hF, 32'd5, 32'h0, 1'b0, 32'h8899AA77, 1'b0);

    // Random traffic over words 16..31, seeded with full-word stores.
    for (int i = 16; i < 32; i++) begin
      ref_mem[i] = 32'd0;
      rand_txn("rinit", 4'hF, 4'h0, 32'(i), $urandom, 1'b0);
    end
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      we = 4'd0; re = 4'd0;
      if (kind < 4)       we = legal_nz();
      else if (kind < 8)  re = legal_nz();
      else if (kind == 8) begin we = legal_nz(); re = legal_nz(); end
      else begin
        case ($urandom_range(0, 2))
          0: re = illegal_mask();
          1: we = illegal_mask();
          default: ;
        endcase
      end
      a = 32'($urandom_range(16, 31));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << DEPTH_LOG2);
      rand_txn("rand", we, re, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
